vga_timing: RTL and testbench

Pixel-timing generator and output stage for the 640x480 Pong display. It divides the system clock down to the pixel rate and runs the horizontal and vertical counters. It drives `X_pix`/`Y_pix` to the combinational draw logic, takes that logic's `draw` result back, and emits the registered pixel together with aligned active-low sync pulses. It also supplies a once-per-frame strobe that game logic uses to advance ball and paddle state.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_timing.sv | 174 +++++++++++++++++
 tb/tb_vga_timing.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared timing constants for the 640x480@60 display and the
//            coordinate type used by the pixel-timing block and draw logic.
// Contents : pix_t            10-bit coordinate (X/Y counts, 0..1023)
//            c_h_* / c_v_*    default horizontal/vertical timing, in pixels
//                             and lines respectively
//            to_pix()         int -> pix_t conversion for localparams
// Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    typedef logic [9:0] pix_t;

    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;

    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;

    function automatic pix_t to_pix(input int value);
        return pix_t'(value);
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_axis_counter
// Purpose  : One display axis: a 0..TOTAL-1 counter that advances on en and
//            wraps, plus region decodes for the current count.
// Params   : TOTAL       counts per period (<= 1024)
//            SYNC_START  first count inside the sync pulse
//            SYNC_END    last count inside the sync pulse
//            VISIBLE     number of visible counts starting at 0
// Ports    : clk      in   system clock
//            rst      in   asynchronous active-high reset
//            en       in   advance the counter by one
//            count    out  current count
//            wrap     out  count is at TOTAL-1 (next advance returns to 0)
//            visible  out  count < VISIBLE
//            in_sync  out  SYNC_START <= count <= SYNC_END
// Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 751,
    parameter int VISIBLE    = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap,
    output logic       visible,
    output logic       in_sync
);

    localparam pix_t c_last       = to_pix(TOTAL - 1);
    localparam pix_t c_sync_start = to_pix(SYNC_START);
    localparam pix_t c_sync_end   = to_pix(SYNC_END);
    localparam pix_t c_visible    = to_pix(VISIBLE);

    pix_t r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= wrap ? '0 : r_count + 10'd1;
        end
    end

    assign count   = r_count;
    assign wrap    = (r_count == c_last);
    assign visible = (r_count < c_visible);
    assign in_sync = (r_count >= c_sync_start) && (r_count <= c_sync_end);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Pixel-timing generator and output stage for the Pong display.
//            Divides clk to the pixel rate, runs the H/V counters, exposes the
//            current coordinate to the draw logic and registers the returned
//            pixel together with active-low syncs (one pixel period behind
//            X_pix/Y_pix). Also produces a one-clk frame strobe.
// Params   : CLK_DIV (1..16) system clocks per pixel; H_* / V_* timing.
// Ports    : clk          in   system clock
//            rst          in   asynchronous active-high reset
//            test_mode    in   select checkerboard instead of draw
//                              (only with VGA_TEST_PATTERN_EN)
//            draw         in   pixel-on request for X_pix/Y_pix
//            X_pix/Y_pix  out  current horizontal / vertical count
//            video_on     out  current count is in the visible region
//            pixel        out  registered pixel
//            hsync_n      out  horizontal sync, active low, registered
//            vsync_n      out  vertical sync, active low, registered
//            frame_start  out  one-clk strobe when the counters return to 0,0
// Macro    : VGA_TEST_PATTERN_EN adds test_mode and a 32-pixel checkerboard.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = c_h_visible,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back
) (
    input  logic       clk,
    input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       test_mode,
`endif
    input  logic       draw,
    output logic [9:0] X_pix,
    output logic [9:0] Y_pix,
    output logic       video_on,
    output logic       pixel,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);

    localparam int c_h_total      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int c_h_sync_start = H_VISIBLE + H_FRONT;
    localparam int c_v_sync_start = V_VISIBLE + V_FRONT;

    logic w_tick;
    logic w_h_wrap, w_h_visible, w_h_in_sync;
    logic w_v_wrap, w_v_visible, w_v_in_sync;
    logic w_video_on;
    logic w_src;
    pix_t w_h, w_v;

    logic r_pixel;
    logic r_hsync_n;
    logic r_vsync_n;
    logic r_frame_start;

    // ------------------------------------------------------------------
    // Pixel-rate divider: tick marks the last clk of each pixel period.
    // ------------------------------------------------------------------
    generate
        if (CLK_DIV <= 1) begin : g_div_bypass
            assign w_tick = 1'b1;
        end else begin : g_div_count
            localparam int c_div_w = $clog2(CLK_DIV);
            localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

            logic [c_div_w-1:0] r_div;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_div <= '0;
                end else if (r_div == c_div_last) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_tick = (r_div == c_div_last);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Axis counters; vertical advances only on the last pixel of a line.
    // ------------------------------------------------------------------
    vga_axis_counter #(
        .TOTAL      (c_h_total),
        .SYNC_START (c_h_sync_start),
        .SYNC_END   (c_h_sync_start + H_SYNC - 1),
        .VISIBLE    (H_VISIBLE)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (w_tick),
        .count   (w_h),
        .wrap    (w_h_wrap),
        .visible (w_h_visible),
        .in_sync (w_h_in_sync)
    );

    vga_axis_counter #(
        .TOTAL      (c_v_total),
        .SYNC_START (c_v_sync_start),
        .SYNC_END   (c_v_sync_start + V_SYNC - 1),
        .VISIBLE    (V_VISIBLE)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .en      (w_tick && w_h_wrap),
        .count   (w_v),
        .wrap    (w_v_wrap),
        .visible (w_v_visible),
        .in_sync (w_v_in_sync)
    );

    assign w_video_on = w_h_visible && w_v_visible;

    // Pixel source ahead of the output register.
`ifdef VGA_TEST_PATTERN_EN
    assign w_src = test_mode ? (w_h[5] ^ w_v[5]) : draw;
`else
    assign w_src = draw;
`endif

    // ------------------------------------------------------------------
    // Output stage: captures the decode of the count being left on this
    // tick, so pixel and syncs trail X_pix/Y_pix by one pixel period and
    // stay aligned with each other.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixel   <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
        end else if (w_tick) begin
            r_pixel   <= w_src && w_video_on;
            r_hsync_n <= !w_h_in_sync;
            r_vsync_n <= !w_v_in_sync;
        end
    end

    // Raised on the same edge that moves the counters from the last
    // position back to 0,0. Reset itself starts at 0,0 without passing
    // through that edge, so the first frame after reset gets no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
        end
    end

    assign X_pix       = w_h;
    assign Y_pix       = w_v;
    assign video_on    = w_video_on;
    assign pixel       = r_pixel;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign frame_start = r_frame_start;

endmodule : vga_timing
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing. Two instances with reduced
//            timing (CLK_DIV=3 and CLK_DIV=1) are driven from a random draw
//            bitmap and random-length segments separated by async resets.
//            Expected outputs are computed from the elapsed clk count.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing;

    localparam int HV = 40, HF = 4, HS = 6, HB = 6;
    localparam int VV = 36, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int DIV_A = 3;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       map [0:VT-1][0:HT-1];
    logic       tm = 1'b0;

    logic       draw_a, draw_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    logic       von_a, pix_a, hs_a, vs_a, fs_a;
    logic       von_b, pix_b, hs_b, vs_b, fs_b;

    int n = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Draw logic: a random bitmap looked up at the current coordinate.
    always_comb begin
        draw_a = 1'b0;
        if (int'(y_a) < VT && int'(x_a) < HT) draw_a = map[int'(y_a)][int'(x_a)];
    end
    always_comb begin
        draw_b = 1'b0;
        if (int'(y_b) < VT && int'(x_b) < HT) draw_b = map[int'(y_b)][int'(x_b)];
    end

    vga_timing #(
        .CLK_DIV(DIV_A), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut_a (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm),
`endif
        .draw(draw_a), .X_pix(x_a), .Y_pix(y_a), .video_on(von_a),
        .pixel(pix_a), .hsync_n(hs_a), .vsync_n(vs_a), .frame_start(fs_a)
    );

    vga_timing #(
        .CLK_DIV(DIV_B), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut_b (
        .clk(clk), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(tm),
`endif
        .draw(draw_b), .X_pix(x_b), .Y_pix(y_b), .video_on(von_b),
        .pixel(pix_b), .hsync_n(hs_b), .vsync_n(vs_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (clk %0d since reset, t=%0t)",
                     tag, got, exp, n, $time);
        end
    endtask

    // ---------------- reference model (n = clk edges since release) -------
    function automatic int cur_pos(input int cnt, input int div);
        return (cnt / div) % FR;
    endfunction

    function automatic int exp_x(input int cnt, input int div);
        return cur_pos(cnt, div) % HT;
    endfunction

    function automatic int exp_y(input int cnt, input int div);
        return cur_pos(cnt, div) / HT;
    endfunction

    function automatic int exp_von(input int cnt, input int div);
        return (exp_x(cnt, div) < HV && exp_y(cnt, div) < VV) ? 1 : 0;
    endfunction

    // Position whose decode the output stage currently holds; -1 = none yet.
    function automatic int prev_pos(input int cnt, input int div);
        if (cnt / div == 0) return -1;
        return (cnt / div - 1) % FR;
    endfunction

    function automatic int exp_pix(input int cnt, input int div);
        int p, h, v, src;
        p = prev_pos(cnt, div);
        if (p < 0) return 0;
        h = p % HT;
        v = p / HT;
        if (tm) src = ((h / 32) % 2) ^ ((v / 32) % 2);
        else    src = map[v][h] ? 1 : 0;
        return (h < HV && v < VV) ? src : 0;
    endfunction

    function automatic int exp_hs(input int cnt, input int div);
        int p, h;
        p = prev_pos(cnt, div);
        if (p < 0) return 1;
        h = p % HT;
        return (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
    endfunction

    function automatic int exp_vs(input int cnt, input int div);
        int p, v;
        p = prev_pos(cnt, div);
        if (p < 0) return 1;
        v = p / HT;
        return (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
    endfunction

    function automatic int exp_fs(input int cnt, input int div);
        int t;
        t = cnt / div;
        return (cnt > 0 && cnt % div == 0 && t % FR == 0) ? 1 : 0;
    endfunction

    task automatic check_all();
        check("x_a",   32'(x_a),   32'(exp_x(n, DIV_A)));
        check("y_a",   32'(y_a),   32'(exp_y(n, DIV_A)));
        check("von_a", 32'(von_a), 32'(exp_von(n, DIV_A)));
        check("pix_a", 32'(pix_a), 32'(exp_pix(n, DIV_A)));
        check("hs_a",  32'(hs_a),  32'(exp_hs(n, DIV_A)));
        check("vs_a",  32'(vs_a),  32'(exp_vs(n, DIV_A)));
        check("fs_a",  32'(fs_a),  32'(exp_fs(n, DIV_A)));
        check("x_b",   32'(x_b),   32'(exp_x(n, DIV_B)));
        check("y_b",   32'(y_b),   32'(exp_y(n, DIV_B)));
        check("von_b", 32'(von_b), 32'(exp_von(n, DIV_B)));
        check("pix_b", 32'(pix_b), 32'(exp_pix(n, DIV_B)));
        check("hs_b",  32'(hs_b),  32'(exp_hs(n, DIV_B)));
        check("vs_b",  32'(vs_b),  32'(exp_vs(n, DIV_B)));
        check("fs_b",  32'(fs_b),  32'(exp_fs(n, DIV_B)));
    endtask

    task automatic randomize_map();
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
                map[v][h] = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge; samples every following negedge.
    task automatic run(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            check_all();
        end
    endtask

    // Asynchronous reset mid-frame: outputs must be at reset values 1 ns
    // after rst rises, well before the next clk edge.
    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        n = 0;
        check_all();
        randomize_map();
`ifdef VGA_TEST_PATTERN_EN
        tm = 1'($urandom_range(0, 1));
`endif
        @(negedge clk);
        check_all();
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        randomize_map();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n = 0;
        check_all();
        rst = 1'b0;
        check_all();
        // Beyond one full frame of the slow instance: several strobes.
        run(3 * FR + 200);
        for (int s = 0; s < 3; s++) begin
            reset_pulse();
            run($urandom_range(100, 3000));
        end
        reset_pulse();
        run(DIV_A * FR + 50);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_vga_timing
`default_nettype wire
